// File: rtl/rggen_axi4lite_if.sv
// AXI4-Lite bundle shared by the register-bus arbiter and its neighbours.
// "master" drives the request channels; "slave" answers them.
interface rggen_axi4lite_if #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;

    logic                     awvalid;
    logic                     awready;
    logic [IDW-1:0]           awid;
    logic [ADDRESS_WIDTH-1:0] awaddr;
    logic [2:0]               awprot;
    logic                     wvalid;
    logic                     wready;
    logic [BUS_WIDTH-1:0]     wdata;
    logic [BUS_WIDTH/8-1:0]   wstrb;
    logic                     bvalid;
    logic                     bready;
    logic [IDW-1:0]           bid;
    logic [1:0]               bresp;
    logic                     arvalid;
    logic                     arready;
    logic [IDW-1:0]           arid;
    logic [ADDRESS_WIDTH-1:0] araddr;
    logic [2:0]               arprot;
    logic                     rvalid;
    logic                     rready;
    logic [IDW-1:0]           rid;
    logic [1:0]               rresp;
    logic [BUS_WIDTH-1:0]     rdata;

    modport master (
        output awvalid, awid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bid, bresp,
        output bready,
        output arvalid, arid, araddr, arprot,
        input  arready,
        input  rvalid, rid, rresp, rdata,
        output rready
    );

    modport slave (
        input  awvalid, awid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bid, bresp,
        input  bready,
        input  arvalid, arid, araddr, arprot,
        output arready,
        output rvalid, rid, rresp, rdata,
        input  rready
    );
endinterface

// File: rtl/rggen_axi4lite_arbiter.sv
// Two-port AXI4-Lite arbiter: round-robin between ports, one transaction
// outstanding downstream, read/write alternation within a port.
module rggen_axi4lite_arbiter #(
    parameter int ID_WIDTH      = 0,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input logic            i_clk,
    input logic            i_rst_n,
    rggen_axi4lite_if.slave  slave_if[2],
    rggen_axi4lite_if.master master_if
);
    localparam int IDW = (ID_WIDTH > 0) ? ID_WIDTH : 1;
    localparam int AW  = ADDRESS_WIDTH;
    localparam int DW  = BUS_WIDTH;
    localparam int SW  = BUS_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP
    } state_e;

    state_e state_q, state_d, state;
    logic   ptr_q, ptr_d;
    logic   gnt_q, gnt_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;
    logic [1:0] last_op_q, last_op_d;

    logic [1:0]     s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready;
    logic [1:0]     s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
    logic [IDW-1:0] s_awid [2];
    logic [IDW-1:0] s_arid [2];
    logic [AW-1:0]  s_awaddr [2];
    logic [AW-1:0]  s_araddr [2];
    logic [2:0]     s_awprot [2];
    logic [2:0]     s_arprot [2];
    logic [DW-1:0]  s_wdata [2];
    logic [SW-1:0]  s_wstrb [2];

    logic [1:0] wr_req, rd_req;
    logic       any_req, sel, sel_wr;
    logic       m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready;

    for (genvar i = 0; i < 2; i++) begin : g_port
        assign s_awvalid[i] = slave_if[i].awvalid;
        assign s_awid[i]    = slave_if[i].awid;
        assign s_awaddr[i]  = slave_if[i].awaddr;
        assign s_awprot[i]  = slave_if[i].awprot;
        assign s_wvalid[i]  = slave_if[i].wvalid;
        assign s_wdata[i]   = slave_if[i].wdata;
        assign s_wstrb[i]   = slave_if[i].wstrb;
        assign s_bready[i]  = slave_if[i].bready;
        assign s_arvalid[i] = slave_if[i].arvalid;
        assign s_arid[i]    = slave_if[i].arid;
        assign s_araddr[i]  = slave_if[i].araddr;
        assign s_arprot[i]  = slave_if[i].arprot;
        assign s_rready[i]  = slave_if[i].rready;

        assign slave_if[i].awready = s_awready[i];
        assign slave_if[i].wready  = s_wready[i];
        assign slave_if[i].arready = s_arready[i];
        assign slave_if[i].bvalid  = s_bvalid[i];
        assign slave_if[i].rvalid  = s_rvalid[i];
        assign slave_if[i].bid     = master_if.bid;
        assign slave_if[i].bresp   = master_if.bresp;
        assign slave_if[i].rid     = master_if.rid;
        assign slave_if[i].rresp   = master_if.rresp;
        assign slave_if[i].rdata   = master_if.rdata;
    end

    assign wr_req  = s_awvalid & s_wvalid;
    assign rd_req  = s_arvalid;
    assign any_req = |(wr_req | rd_req);

    // last_op_q bit set means the port's last grant was a write
    always_comb begin
        sel    = (wr_req[ptr_q] | rd_req[ptr_q]) ? ptr_q : ~ptr_q;
        sel_wr = wr_req[sel] & (~rd_req[sel] | ~last_op_q[sel]);
    end

    // Reset masks the decoded state so every valid/ready drops at once
    always_comb begin
        state = i_rst_n ? state_q : IDLE;
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        last_op_d = last_op_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_arvalid = 1'b0;
        m_bready  = 1'b0;
        m_rready  = 1'b0;
        s_awready = '0;
        s_wready  = '0;
        s_arready = '0;
        s_bvalid  = '0;
        s_rvalid  = '0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_d          = sel;
                    ptr_d          = ~sel;
                    last_op_d[sel] = sel_wr;
                    state_d        = sel_wr ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                m_awvalid = s_awvalid[gnt_q] & ~aw_done_q;
                m_wvalid  = s_wvalid[gnt_q] & ~w_done_q;
                s_awready[gnt_q] = master_if.awready & ~aw_done_q;
                s_wready[gnt_q]  = master_if.wready & ~w_done_q;
                aw_done_d = aw_done_q | (m_awvalid & master_if.awready);
                w_done_d  = w_done_q | (m_wvalid & master_if.wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            WR_RESP: begin
                m_bready        = s_bready[gnt_q];
                s_bvalid[gnt_q] = master_if.bvalid;
                if (master_if.bvalid && m_bready) begin
                    state_d = IDLE;
                end
            end
            RD_REQ: begin
                m_arvalid        = s_arvalid[gnt_q];
                s_arready[gnt_q] = master_if.arready;
                if (m_arvalid && master_if.arready) begin
                    state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                m_rready        = s_rready[gnt_q];
                s_rvalid[gnt_q] = master_if.rvalid;
                if (master_if.rvalid && m_rready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            gnt_q     <= 1'b0;
            last_op_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            last_op_q <= last_op_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    assign master_if.awvalid = m_awvalid;
    assign master_if.awid    = s_awid[gnt_q];
    assign master_if.awaddr  = s_awaddr[gnt_q];
    assign master_if.awprot  = s_awprot[gnt_q];
    assign master_if.wvalid  = m_wvalid;
    assign master_if.wdata   = s_wdata[gnt_q];
    assign master_if.wstrb   = s_wstrb[gnt_q];
    assign master_if.bready  = m_bready;
    assign master_if.arvalid = m_arvalid;
    assign master_if.arid    = s_arid[gnt_q];
    assign master_if.araddr  = s_araddr[gnt_q];
    assign master_if.arprot  = s_arprot[gnt_q];
    assign master_if.rready  = m_rready;
endmodule

// File: tb/tb_rggen_axi4lite_arbiter.sv
// Directed bench for the two-port AXI4-Lite arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_rggen_axi4lite_arbiter;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_REQ  = 3'd1;
    localparam logic [2:0] ST_WR_RESP = 3'd2;
    localparam logic [2:0] ST_RD_REQ  = 3'd3;
    localparam logic [2:0] ST_RD_RESP = 3'd4;

    logic i_clk = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    always #5 i_clk = ~i_clk;

    rggen_axi4lite_if #(.ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) up_if[2] ();
    rggen_axi4lite_if #(.ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dn_if ();

    rggen_axi4lite_arbiter #(
        .ID_WIDTH(0), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .slave_if (up_if),
        .master_if(dn_if)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_all();
        up_if[0].awvalid = 0; up_if[0].awid = 0; up_if[0].awaddr = 0;
        up_if[0].awprot = 0;  up_if[0].wvalid = 0; up_if[0].wdata = 0;
        up_if[0].wstrb = 0;   up_if[0].bready = 0; up_if[0].arvalid = 0;
        up_if[0].arid = 0;    up_if[0].araddr = 0; up_if[0].arprot = 0;
        up_if[0].rready = 0;
        up_if[1].awvalid = 0; up_if[1].awid = 0; up_if[1].awaddr = 0;
        up_if[1].awprot = 0;  up_if[1].wvalid = 0; up_if[1].wdata = 0;
        up_if[1].wstrb = 0;   up_if[1].bready = 0; up_if[1].arvalid = 0;
        up_if[1].arid = 0;    up_if[1].araddr = 0; up_if[1].arprot = 0;
        up_if[1].rready = 0;
        dn_if.awready = 0; dn_if.wready = 0; dn_if.bvalid = 0;
        dn_if.bid = 0;     dn_if.bresp = 0;  dn_if.arready = 0;
        dn_if.rvalid = 0;  dn_if.rid = 0;    dn_if.rresp = 0;
        dn_if.rdata = 0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        clr_all();
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    logic [2:0] seq [8];

    initial begin
        clr_all();
        tick();
        tick();
        // reset state
        chk("rst_awvalid", dn_if.awvalid, 0);
        chk("rst_arvalid", dn_if.arvalid, 0);
        chk("rst_bready", dn_if.bready, 0);
        chk("rst_up0_awready", up_if[0].awready, 0);
        chk("rst_state", dut.state_q, ST_IDLE);
        i_rst_n = 1'b1;
        #1;
        chk("post_rst_wvalid", dn_if.wvalid, 0);

        // port 0 write, downstream always ready
        up_if[0].awvalid = 1; up_if[0].wvalid = 1;
        up_if[0].awaddr = 8'h10; up_if[0].wdata = 32'hA5A5A5A5;
        up_if[0].wstrb = 4'hF; up_if[0].bready = 1;
        up_if[1].bready = 1;
        dn_if.awready = 1; dn_if.wready = 1;
        #1;
        chk("s1_lat_awvalid", dn_if.awvalid, 0);
        chk("s1_up1_awready0", up_if[1].awready, 0);
        tick();
        chk("s1_awvalid", dn_if.awvalid, 1);
        chk("s1_wvalid", dn_if.wvalid, 1);
        chk("s1_awaddr", dn_if.awaddr, 8'h10);
        chk("s1_wdata", dn_if.wdata, 32'hA5A5A5A5);
        chk("s1_up0_awready", up_if[0].awready, 1);
        chk("s1_up1_awready", up_if[1].awready, 0);
        chk("s1_up1_wready", up_if[1].wready, 0);
        tick();
        up_if[0].awvalid = 0; up_if[0].wvalid = 0;
        dn_if.bvalid = 1; dn_if.bresp = 2'b00;
        #1;
        chk("s1_state_wresp", dut.state_q, ST_WR_RESP);
        chk("s1_resp_awvalid", dn_if.awvalid, 0);
        chk("s1_bready", dn_if.bready, 1);
        chk("s1_up0_bvalid", up_if[0].bvalid, 1);
        chk("s1_up0_bresp", up_if[0].bresp, 2'b00);
        chk("s1_up1_bvalid", up_if[1].bvalid, 0);
        tick();
        dn_if.bvalid = 0;
        #1;
        chk("s1_idle", dut.state_q, ST_IDLE);
        chk("s1_up0_bvalid_off", up_if[0].bvalid, 0);

        // simultaneous reads from both ports
        do_reset();
        up_if[0].arvalid = 1; up_if[0].araddr = 8'h20; up_if[0].rready = 1;
        up_if[1].arvalid = 1; up_if[1].araddr = 8'h30; up_if[1].rready = 1;
        dn_if.arready = 1;
        #1;
        chk("s2_lat_arvalid", dn_if.arvalid, 0);
        tick();
        chk("s2_arvalid_a", dn_if.arvalid, 1);
        chk("s2_araddr_a", dn_if.araddr, 8'h20);
        chk("s2_up0_arready", up_if[0].arready, 1);
        chk("s2_up1_arready_a", up_if[1].arready, 0);
        tick();
        up_if[0].arvalid = 0;
        dn_if.rvalid = 1; dn_if.rdata = 32'h11111111;
        #1;
        chk("s2_up0_rvalid", up_if[0].rvalid, 1);
        chk("s2_up0_rdata", up_if[0].rdata, 32'h11111111);
        chk("s2_up1_rvalid_a", up_if[1].rvalid, 0);
        tick();
        dn_if.rvalid = 0;
        #1;
        chk("s2_idle_a", dut.state_q, ST_IDLE);
        tick();
        chk("s2_araddr_b", dn_if.araddr, 8'h30);
        chk("s2_up1_arready", up_if[1].arready, 1);
        chk("s2_up0_arready_b", up_if[0].arready, 0);
        tick();
        up_if[1].arvalid = 0;
        dn_if.rvalid = 1; dn_if.rdata = 32'h22222222;
        #1;
        chk("s2_up1_rvalid", up_if[1].rvalid, 1);
        chk("s2_up0_rvalid_b", up_if[0].rvalid, 0);
        tick();
        dn_if.rvalid = 0;

        // port 1 holds read and write requests together
        up_if[1].awvalid = 1; up_if[1].wvalid = 1; up_if[1].arvalid = 1;
        up_if[1].awaddr = 8'h40; up_if[1].araddr = 8'h44;
        up_if[1].bready = 1; up_if[1].rready = 1;
        dn_if.awready = 1; dn_if.wready = 1; dn_if.arready = 1;
        dn_if.bvalid = 1; dn_if.rvalid = 1;
        seq = '{ST_IDLE, ST_WR_REQ, ST_WR_RESP, ST_IDLE,
                ST_RD_REQ, ST_RD_RESP, ST_IDLE, ST_WR_REQ};
        #1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("s3_state_%0d", i), dut.state_q, seq[i]);
            if (seq[i] == ST_WR_REQ)
                chk($sformatf("s3_awaddr_%0d", i), dn_if.awaddr, 8'h40);
            if (seq[i] == ST_RD_REQ)
                chk($sformatf("s3_araddr_%0d", i), dn_if.araddr, 8'h44);
            tick();
        end

        // AW accepted three cycles before W
        do_reset();
        up_if[0].awvalid = 1; up_if[0].wvalid = 1;
        up_if[0].awaddr = 8'h50; up_if[0].wdata = 32'h12345678;
        up_if[0].wstrb = 4'hF; up_if[0].bready = 1;
        tick();
        dn_if.awready = 1;
        #1;
        chk("s4_awvalid", dn_if.awvalid, 1);
        chk("s4_up0_awready", up_if[0].awready, 1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("s4_aw_drop_%0d", i), dn_if.awvalid, 0);
            chk($sformatf("s4_w_hold_%0d", i), dn_if.wvalid, 1);
            chk($sformatf("s4_up_awready_%0d", i), up_if[0].awready, 0);
            chk($sformatf("s4_state_%0d", i), dut.state_q, ST_WR_REQ);
        end
        tick();
        dn_if.wready = 1;
        #1;
        chk("s4_wready", up_if[0].wready, 1);
        chk("s4_wvalid_last", dn_if.wvalid, 1);
        tick();
        up_if[0].awvalid = 0; up_if[0].wvalid = 0;
        dn_if.awready = 0; dn_if.wready = 0;
        #1;
        chk("s4_state_wresp", dut.state_q, ST_WR_RESP);
        chk("s4_wvalid_off", dn_if.wvalid, 0);
        dn_if.bvalid = 1;
        tick();
        dn_if.bvalid = 0;

        // read response held off by upstream rready
        up_if[0].arvalid = 1; up_if[0].araddr = 8'h60;
        dn_if.arready = 1;
        tick();
        chk("s5_araddr", dn_if.araddr, 8'h60);
        tick();
        up_if[0].arvalid = 0;
        dn_if.rvalid = 1;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s5_rready_%0d", i), dn_if.rready, 0);
            chk($sformatf("s5_state_%0d", i), dut.state_q, ST_RD_RESP);
            tick();
        end
        up_if[0].rready = 1;
        #1;
        chk("s5_rready_on", dn_if.rready, 1);
        tick();
        dn_if.rvalid = 0;
        #1;
        chk("s5_idle", dut.state_q, ST_IDLE);

        // reset in WR_RESP, then a port 1 read
        up_if[0].awvalid = 1; up_if[0].wvalid = 1;
        dn_if.awready = 1; dn_if.wready = 1;
        tick();
        tick();
        up_if[0].awvalid = 0; up_if[0].wvalid = 0;
        #1;
        chk("s6_state_wresp", dut.state_q, ST_WR_RESP);
        i_rst_n = 1'b0;
        dn_if.bvalid = 1;
        #1;
        chk("s6_rst_bvalid", up_if[0].bvalid, 0);
        chk("s6_rst_bready", dn_if.bready, 0);
        tick();
        i_rst_n = 1'b1;
        #1;
        chk("s6_idle", dut.state_q, ST_IDLE);
        chk("s6_bvalid", up_if[0].bvalid, 0);
        chk("s6_awvalid", dn_if.awvalid, 0);
        dn_if.bvalid = 0;
        up_if[1].awvalid = 0; up_if[1].wvalid = 0;
        up_if[1].arvalid = 1; up_if[1].araddr = 8'h70; up_if[1].rready = 1;
        dn_if.arready = 1;
        #1;
        chk("s6_lat_arvalid", dn_if.arvalid, 0);
        tick();
        chk("s6_arvalid", dn_if.arvalid, 1);
        chk("s6_araddr", dn_if.araddr, 8'h70);
        chk("s6_up1_arready", up_if[1].arready, 1);
        tick();
        up_if[1].arvalid = 0;
        dn_if.rvalid = 1;
        #1;
        chk("s6_up1_rvalid", up_if[1].rvalid, 1);
        tick();
        dn_if.rvalid = 0;
        #1;
        chk("s6_end_idle", dut.state_q, ST_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
